// File: rtl/rf_writeback_if.sv
// rf_writeback_if: upstream instruction, data-memory response and register-file write bundle
interface rf_writeback_if;
  logic        valid;
  logic        ready;
  logic        wen;
  logic        is_load;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regwrite;
  logic [4:0]  wr_rd;
  logic [31:0] wd;
  logic        err;
  logic        busy;
  modport master (
    output valid, wen, is_load, funct3, addr_lo, rd, alu_result, mem_rvalid, mem_rdata,
    input  ready, regwrite, wr_rd, wd, err, busy
  );
  modport slave (
    input  valid, wen, is_load, funct3, addr_lo, rd, alu_result, mem_rvalid, mem_rdata,
    output ready, regwrite, wr_rd, wd, err, busy
  );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: register-file writeback with load extraction/extension and x0 suppression.
// Optional WB_LOAD_TIMEOUT_EN aborts a load after TIMEOUT_CYCLES cycles without a response.
module rf_writeback #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic          clk_i,
  input logic          reset_i,
  rf_writeback_if.slave bus
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t      state, state_n;
  logic [4:0]  l_rd, rd_q, rd_n;
  logic [2:0]  l_f3;
  logic [1:0]  l_addr;
  logic        l_wen;
  logic        regwrite_q, regwrite_n, err_q, err_n;
  logic [31:0] wd_q, wd_n, ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fire, bad, tmo;

  always_comb begin
    fire     = bus.valid && state == IDLE;
    bad      = bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11 ||
               (bus.funct3[1:0] == 2'b01 && bus.addr_lo[0]) ||
               (bus.funct3 == 3'b010 && bus.addr_lo != 2'b00);
    byte_sel = bus.mem_rdata[{l_addr, 3'b000} +: 8];
    half_sel = bus.mem_rdata[{l_addr[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants, so it gates the sign fill
    ext      = l_f3[1] ? bus.mem_rdata :
               l_f3[0] ? {{16{!l_f3[2] && half_sel[15]}}, half_sel} :
                         {{24{!l_f3[2] && byte_sel[7]}}, byte_sel};
  end

`ifdef WB_LOAD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_i)
    cnt <= (reset_i && state == WAIT_LOAD && !bus.mem_rvalid) ? cnt + 1'b1 : '0;
  // abort on the edge where the count would reach TIMEOUT_CYCLES; a response that cycle wins
  assign tmo = state == WAIT_LOAD && !bus.mem_rvalid && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      regwrite_q <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      l_rd       <= '0;
      l_f3       <= '0;
      l_addr     <= '0;
      l_wen      <= 1'b0;
    end else begin
      state      <= state_n;
      regwrite_q <= regwrite_n;
      err_q      <= err_n;
      rd_q       <= rd_n;
      wd_q       <= wd_n;
      if (fire && bus.is_load) begin
        l_rd   <= bus.rd;
        l_f3   <= bus.funct3;
        l_addr <= bus.addr_lo;
        l_wen  <= bus.wen;
      end
    end
  end

  always_comb begin
    state_n = state == IDLE ? ((fire && bus.is_load && !bad) ? WAIT_LOAD : IDLE)
                            : ((bus.mem_rvalid || tmo) ? IDLE : WAIT_LOAD);
  end

  always_comb begin
    regwrite_n = 1'b0;
    err_n      = 1'b0;
    rd_n       = rd_q;
    wd_n       = wd_q;
    if (fire && !bus.is_load) begin
      regwrite_n = bus.wen && bus.rd != 5'd0;
      rd_n       = bus.rd;
      wd_n       = bus.alu_result;
    end else if (fire && bad) begin
      err_n = 1'b1;
    end else if (state == WAIT_LOAD && bus.mem_rvalid) begin
      regwrite_n = l_wen && l_rd != 5'd0;
      rd_n       = l_rd;
      wd_n       = ext;
    end else if (tmo) begin
      err_n = 1'b1;
    end
  end

  assign bus.ready    = state == IDLE;
  assign bus.busy     = state == WAIT_LOAD;
  assign bus.regwrite = regwrite_q;
  assign bus.wr_rd    = rd_q;
  assign bus.wd       = wd_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed scenarios with hand-computed expectations for rf_writeback
module tb_rf_writeback;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  rf_writeback_if bus();
  rf_writeback #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk_i(clk), .reset_i(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 0; bus.wen = 0; bus.is_load = 0; bus.funct3 = 0; bus.addr_lo = 0;
    bus.rd = 0; bus.alu_result = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] r);
    bus.valid = 1; bus.is_load = 1; bus.wen = 1; bus.funct3 = f3; bus.addr_lo = a; bus.rd = r;
    step();
    bus.valid = 0; bus.is_load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    step(); step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.ready); end
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL reset_rw got %0b want 0", bus.regwrite); end
    checks++; if (bus.wr_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", bus.wr_rd); end
    checks++; if (bus.wd !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", bus.wd); end
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_err_busy got %0b%0b want 00", bus.err, bus.busy); end
    reset_n = 1;
    step();
  endtask

  task automatic test_alu();
    bus.valid = 1; bus.wen = 1; bus.rd = 5; bus.alu_result = 32'h0000_1234;
    step();
    bus.valid = 0;
    checks++; if (bus.regwrite !== 1'b1) begin errors++; $display("FAIL alu_rw got %0b want 1", bus.regwrite); end
    checks++; if (bus.wr_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", bus.wr_rd); end
    checks++; if (bus.wd !== 32'h0000_1234) begin errors++; $display("FAIL alu_wd got %h want 00001234", bus.wd); end
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL alu_rw_drop got %0b want 0", bus.regwrite); end
    checks++; if (bus.wd !== 32'h0000_1234) begin errors++; $display("FAIL alu_wd_hold got %h want 00001234", bus.wd); end
  endtask

  task automatic test_x0();
    bus.valid = 1; bus.wen = 1; bus.rd = 0; bus.alu_result = 32'hDEAD_BEEF;
    step();
    bus.valid = 0;
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL x0_rw got %0b want 0", bus.regwrite); end
    checks++; if (bus.wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_wd got %h want deadbeef", bus.wd); end
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL x0_rw2 got %0b want 0", bus.regwrite); end
    bus.wen = 0; bus.rd = 6; bus.alu_result = 32'h77; bus.valid = 1;
    step();
    bus.valid = 0;
    checks++; if (bus.regwrite !== 1'b0 || bus.wr_rd !== 5'd6) begin errors++; $display("FAIL nowen got rw=%0b rd=%0d want rw=0 rd=6", bus.regwrite, bus.wr_rd); end
  endtask

  task automatic test_back_to_back();
    bus.valid = 1; bus.wen = 1; bus.rd = 3; bus.alu_result = 32'h11;
    step();
    checks++; if (bus.regwrite !== 1'b1 || bus.wr_rd !== 5'd3 || bus.wd !== 32'h11) begin errors++; $display("FAIL b2b_0 got rw=%0b rd=%0d wd=%h want 1 3 00000011", bus.regwrite, bus.wr_rd, bus.wd); end
    bus.rd = 4; bus.alu_result = 32'h22;
    step();
    bus.valid = 0;
    checks++; if (bus.regwrite !== 1'b1 || bus.wr_rd !== 5'd4 || bus.wd !== 32'h22) begin errors++; $display("FAIL b2b_1 got rw=%0b rd=%0d wd=%h want 1 4 00000022", bus.regwrite, bus.wr_rd, bus.wd); end
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b want 0", bus.regwrite); end
  endtask

  task automatic test_lb();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
    issue_load(3'b000, 2'd2, 5'd7);
    bus.mem_rvalid = 0;
    checks++; if (bus.busy !== 1'b1 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL lb_enter got busy=%0b rw=%0b want 1 0", bus.busy, bus.regwrite); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL lb_wait_ready%0d got %0b want 0", i, bus.ready); end
      if (i < 2) step();
    end
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0080_0000;
    step();
    bus.mem_rvalid = 0;
    checks++; if (bus.regwrite !== 1'b1 || bus.wr_rd !== 5'd7) begin errors++; $display("FAIL lb_write got rw=%0b rd=%0d want 1 7", bus.regwrite, bus.wr_rd); end
    checks++; if (bus.wd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wd got %h want ffffff80", bus.wd); end
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL lb_idle got ready=%0b busy=%0b want 1 0", bus.ready, bus.busy); end
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL lb_rw_drop got %0b want 0", bus.regwrite); end
  endtask

  task automatic test_extract();
    logic [2:0]  f3 [5] = '{3'b101, 3'b001, 3'b100, 3'b010, 3'b000};
    logic [1:0]  ad [5] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
    logic [31:0] md [5] = '{32'h8001_0000, 32'h0000_8001, 32'hAB00_0000, 32'hCAFE_BABE, 32'h0000_7F00};
    logic [31:0] ex [5] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_00AB, 32'hCAFE_BABE, 32'h0000_007F};
    for (int i = 0; i < 5; i++) begin
      issue_load(f3[i], ad[i], 5'(10 + i));
      bus.mem_rvalid = 1; bus.mem_rdata = md[i];
      step();
      bus.mem_rvalid = 0;
      checks++; if (bus.regwrite !== 1'b1 || bus.wr_rd !== 5'(10 + i) || bus.wd !== ex[i]) begin errors++; $display("FAIL extract%0d got rw=%0b rd=%0d wd=%h want 1 %0d %h", i, bus.regwrite, bus.wr_rd, bus.wd, 10 + i, ex[i]); end
    end
    step();
  endtask

  task automatic test_errors();
    logic [2:0] f3 [4] = '{3'b010, 3'b011, 3'b001, 3'b111};
    logic [1:0] ad [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      issue_load(f3[i], ad[i], 5'd9);
      checks++; if (bus.err !== 1'b1 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL err%0d got err=%0b rw=%0b want 1 0", i, bus.err, bus.regwrite); end
      checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL err%0d_state got ready=%0b busy=%0b want 1 0", i, bus.ready, bus.busy); end
      step();
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err%0d_pulse got %0b want 0", i, bus.err); end
    end
  endtask

  task automatic test_load_x0();
    issue_load(3'b010, 2'd0, 5'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_rvalid = 0;
    checks++; if (bus.regwrite !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL ldx0 got rw=%0b ready=%0b want 0 1", bus.regwrite, bus.ready); end
  endtask

  task automatic test_reset_in_wait();
    issue_load(3'b000, 2'd0, 5'd8);
    step();
    reset_n = 0;
    step();
    reset_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    step();
    bus.mem_rvalid = 0;
    checks++; if (bus.regwrite !== 1'b0 || bus.ready !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_wait got rw=%0b ready=%0b err=%0b want 0 1 0", bus.regwrite, bus.ready, bus.err); end
  endtask

`ifdef WB_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    issue_load(3'b010, 2'd0, 5'd12);
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d got err=%0b busy=%0b want 0 1", i, bus.err, bus.busy); end
    end
    step();
    checks++; if (bus.err !== 1'b1 || bus.ready !== 1'b1 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL tmo_fire got err=%0b ready=%0b rw=%0b want 1 1 0", bus.err, bus.ready, bus.regwrite); end
    step();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %0b want 0", bus.err); end
    issue_load(3'b010, 2'd0, 5'd13);
    step(); step(); step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0055;
    step();
    bus.mem_rvalid = 0;
    checks++; if (bus.regwrite !== 1'b1 || bus.err !== 1'b0 || bus.wd !== 32'h55) begin errors++; $display("FAIL tmo_race got rw=%0b err=%0b wd=%h want 1 0 00000055", bus.regwrite, bus.err, bus.wd); end
  endtask
`else
  task automatic test_timeout();
    issue_load(3'b010, 2'd0, 5'd12);
    for (int i = 0; i < 10; i++) step();
    checks++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL notmo got busy=%0b err=%0b want 1 0", bus.busy, bus.err); end
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0055;
    step();
    bus.mem_rvalid = 0;
    checks++; if (bus.regwrite !== 1'b1 || bus.wd !== 32'h55) begin errors++; $display("FAIL notmo_write got rw=%0b wd=%h want 1 00000055", bus.regwrite, bus.wd); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_x0();
    test_back_to_back();
    test_lb();
    test_extract();
    test_errors();
    test_load_x0();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
